// File: rtl/pop_sequencer_pkg.sv
// Shared types and constants for the POP cycle sequencer.
// One tick of clk_2M5 is TICK_NS nanoseconds.
package pop_timing_pkg;

  localparam int DUR_W_DEFAULT = 16;
  localparam int CNT_W_DEFAULT = 32;
  localparam int TICK_NS       = 400;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_PUMP   = 4'd1,
    ST_DEAD1  = 4'd2,
    ST_MW1    = 4'd3,
    ST_RAMSEY = 4'd4,
    ST_MW2    = 4'd5,
    ST_DEAD2  = 4'd6,
    ST_PROBE  = 4'd7,
    ST_END    = 4'd8
  } state_e;

endpackage

// File: rtl/pop_sequencer_if.sv
// Control, duration and gate bundle between host logic and the sequencer.
// master drives control/durations; slave is the sequencer side.
interface pop_sequencer_if
  import pop_timing_pkg::*;
#(
  parameter int DUR_W = DUR_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             run;
  logic             single;
  logic             abort;
  logic [DUR_W-1:0] dur_pump;
  logic [DUR_W-1:0] dur_dead;
  logic [DUR_W-1:0] dur_mw;
  logic [DUR_W-1:0] dur_ramsey;
  logic [DUR_W-1:0] dur_probe;
  logic             pump_out;
  logic             mw_out;
  logic             probe_out;
  logic             busy;
  logic             cycle_done;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output run, single, abort,
    output dur_pump, dur_dead, dur_mw,
    output dur_ramsey, dur_probe,
    input  pump_out, mw_out, probe_out,
    input  busy, cycle_done, cycle_count
  );

  modport slave (
    input  run, single, abort,
    input  dur_pump, dur_dead, dur_mw,
    input  dur_ramsey, dur_probe,
    output pump_out, mw_out, probe_out,
    output busy, cycle_done, cycle_count
  );

endinterface

// File: rtl/pop_sequencer_phase_counter.sv
// Loadable down-counter timing one sequencer phase.
// Holds at zero; o_zero marks the last tick of the phase.
module phase_counter #(
  parameter int DUR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DUR_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [DUR_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DUR_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pop_sequencer.sv
// POP cycle sequencer: pump, dead, mw, ramsey, mw, dead, probe, END.
// Define POP_SEQ_CYCLE_COUNT_EN to build the saturating cycle counter.
module pop_sequencer
  import pop_timing_pkg::*;
#(
  parameter int DUR_W = DUR_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic         clk_2M5,
  input  logic         reset,
  pop_sequencer_if.slave bus
);

  state_e           r_state;
  state_e           w_next;
  logic [DUR_W-1:0] r_dur_pump;
  logic [DUR_W-1:0] r_dur_dead;
  logic [DUR_W-1:0] r_dur_mw;
  logic [DUR_W-1:0] r_dur_ramsey;
  logic [DUR_W-1:0] r_dur_probe;
  logic             r_single;
  logic             r_pump_out;
  logic             r_mw_out;
  logic             r_probe_out;
  logic             r_busy;
  logic             r_done;
  logic             w_latch;
  logic             w_load;
  logic             w_zero;
  logic             w_is_phase;
  logic [DUR_W-1:0] w_dur;
  logic [DUR_W-1:0] w_load_val;
  logic [7:1]       w_nz_in;
  logic [7:1]       w_nz_sh;

  // bit index equals the phase's state encoding
  assign w_nz_in = {
    bus.dur_probe != '0, bus.dur_dead != '0,
    bus.dur_mw != '0,    bus.dur_ramsey != '0,
    bus.dur_mw != '0,    bus.dur_dead != '0,
    bus.dur_pump != '0
  };

  assign w_nz_sh = {
    r_dur_probe != '0, r_dur_dead != '0,
    r_dur_mw != '0,    r_dur_ramsey != '0,
    r_dur_mw != '0,    r_dur_dead != '0,
    r_dur_pump != '0
  };

  function automatic state_e first_phase(
    input int         from,
    input logic [7:1] nz
  );
    state_e s;
    s = ST_END;
    for (int i = 7; i >= 1; i--) begin
      if (i >= from && nz[i]) s = state_e'(i[3:0]);
    end
    return s;
  endfunction

  function automatic logic [DUR_W-1:0] dur_sel(
    input state_e           s,
    input logic [DUR_W-1:0] p,
    input logic [DUR_W-1:0] d,
    input logic [DUR_W-1:0] m,
    input logic [DUR_W-1:0] r,
    input logic [DUR_W-1:0] q
  );
    logic [DUR_W-1:0] v;
    v = '0;
    unique case (s)
      ST_PUMP:           v = p;
      ST_DEAD1, ST_DEAD2: v = d;
      ST_MW1, ST_MW2:     v = m;
      ST_RAMSEY:         v = r;
      ST_PROBE:          v = q;
      default:           v = '0;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk_2M5) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.run && !bus.abort) begin
          w_latch = 1'b1;
          w_next  = first_phase(1, w_nz_in);
        end
      end
      ST_END: begin
        if (bus.abort) begin
          w_next = ST_IDLE;
        end else if (bus.run && !r_single) begin
          w_latch = 1'b1;
          w_next  = first_phase(1, w_nz_in);
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        if (bus.abort) begin
          w_next = ST_IDLE;
        end else if (w_zero) begin
          w_next = first_phase(int'(r_state) + 1, w_nz_sh);
        end
      end
    endcase
  end

  // the entering phase's duration comes straight from the inputs at cycle start
  assign w_dur = w_latch
    ? dur_sel(w_next, bus.dur_pump, bus.dur_dead, bus.dur_mw,
              bus.dur_ramsey, bus.dur_probe)
    : dur_sel(w_next, r_dur_pump, r_dur_dead, r_dur_mw,
              r_dur_ramsey, r_dur_probe);

  assign w_is_phase = (w_next != ST_IDLE) && (w_next != ST_END);
  assign w_load     = w_is_phase && (w_latch || w_zero);
  assign w_load_val = w_dur - DUR_W'(1);

  phase_counter #(.DUR_W(DUR_W)) u_phase_counter (
    .clk        (clk_2M5),
    .rst        (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk_2M5) begin
    if (reset) begin
      r_dur_pump   <= '0;
      r_dur_dead   <= '0;
      r_dur_mw     <= '0;
      r_dur_ramsey <= '0;
      r_dur_probe  <= '0;
      r_single     <= 1'b0;
    end else if (w_latch) begin
      r_dur_pump   <= bus.dur_pump;
      r_dur_dead   <= bus.dur_dead;
      r_dur_mw     <= bus.dur_mw;
      r_dur_ramsey <= bus.dur_ramsey;
      r_dur_probe  <= bus.dur_probe;
      r_single     <= bus.single;
    end
  end

  // outputs register the decode of the next state, so they track r_state
  always_ff @(posedge clk_2M5) begin
    if (reset) begin
      r_pump_out  <= 1'b0;
      r_mw_out    <= 1'b0;
      r_probe_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_pump_out  <= (w_next == ST_PUMP);
      r_mw_out    <= (w_next == ST_MW1) || (w_next == ST_MW2);
      r_probe_out <= (w_next == ST_PROBE);
      r_busy      <= (w_next != ST_IDLE);
      r_done      <= (w_next == ST_END);
    end
  end

  assign bus.pump_out   = r_pump_out;
  assign bus.mw_out     = r_mw_out;
  assign bus.probe_out  = r_probe_out;
  assign bus.busy       = r_busy;
  assign bus.cycle_done = r_done;

`ifdef POP_SEQ_CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_cycle_count;

  always_ff @(posedge clk_2M5) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if (w_next == ST_END && r_cycle_count != '1) begin
      r_cycle_count <= r_cycle_count + CNT_W'(1);
    end
  end

  assign bus.cycle_count = r_cycle_count;
`else
  assign bus.cycle_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pop_sequencer.sv
// Self-checking bench for pop_sequencer: window table plus scoreboard queue.
// Expected count follows POP_SEQ_CYCLE_COUNT_EN.
module tb_pop_sequencer;
  import pop_timing_pkg::*;

  localparam int DW = 16;
  localparam int CW = 4;
`ifdef POP_SEQ_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk_2M5 = 1'b0;
  logic reset   = 1'b1;

  pop_sequencer_if #(.DUR_W(DW), .CNT_W(CW)) bus ();

  pop_sequencer #(.DUR_W(DW), .CNT_W(CW)) dut (
    .clk_2M5 (clk_2M5),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 clk_2M5 = ~clk_2M5;

  // gate windows in ticks after the run edge; empty window is 0..-1
  typedef struct {
    int p0, p1, m0, m1, n0, n1, q0, q1, d;
    int dp, dd, dm, dr, dq;
  } rec_t;

  typedef struct {
    logic [4:0]    g;
    logic [CW-1:0] c;
    int            t;
  } exp_t;

  exp_t q[$];
  rec_t tbl[5];
  rec_t nom, p9, zro;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n        = 0;

  function automatic logic [CW-1:0] cnt_of(input int k);
    int mx;
    mx = (1 << CW) - 1;
    if (!CNT_EN) return '0;
    return (k > mx) ? CW'(mx) : CW'(k);
  endfunction

  function automatic exp_t win(input rec_t r, input int t, input int k);
    exp_t e;
    logic pu, mw, pr;
    pu  = (t >= r.p0 && t <= r.p1);
    mw  = (t >= r.m0 && t <= r.m1) || (t >= r.n0 && t <= r.n1);
    pr  = (t >= r.q0 && t <= r.q1);
    e.g = {pu, mw, pr, t >= 1 && t <= r.d, t == r.d};
    e.c = cnt_of((t >= r.d) ? k + 1 : k);
    e.t = t;
    return e;
  endfunction

  function automatic exp_t idle(input int t, input int k);
    exp_t e;
    e.g = 5'b00000;
    e.c = cnt_of(k);
    e.t = t;
    return e;
  endfunction

  function automatic exp_t endt(input int t, input int k);
    exp_t e;
    e.g = 5'b00011;
    e.c = cnt_of(k);
    e.t = t;
    return e;
  endfunction

  task automatic set_dur(input rec_t r);
    bus.dur_pump   = DW'(r.dp);
    bus.dur_dead   = DW'(r.dd);
    bus.dur_mw     = DW'(r.dm);
    bus.dur_ramsey = DW'(r.dr);
    bus.dur_probe  = DW'(r.dq);
  endtask

  task automatic check();
    exp_t       e;
    logic [4:0] got;
    if (q.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard empty at %0t", $time);
      return;
    end
    e   = q.pop_front();
    got = {bus.pump_out, bus.mw_out, bus.probe_out,
           bus.busy, bus.cycle_done};
    n_assert++;
    if (got !== e.g) begin
      n_fail++;
      $display("FAIL gates t=%0d got=%b exp=%b (pump,mw,probe,busy,done)",
               e.t, got, e.g);
    end
    n_assert++;
    if (bus.cycle_count !== e.c) begin
      n_fail++;
      $display("FAIL count t=%0d got=%0d exp=%0d",
               e.t, bus.cycle_count, e.c);
    end
  endtask

  task automatic run_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk_2M5);
      check();
    end
  endtask

  initial begin
    tbl[0] = '{1, 5, 8, 10, 21, 23, 26, 29, 30, 5, 2, 3, 10, 4};
    tbl[1] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 1, 0, 1, 0, 1};
    tbl[2] = '{0, -1, 0, -1, 0, -1, 0, -1, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{0, -1, 2, 3, 4, 5, 7, 9, 10, 0, 1, 2, 0, 3};
    tbl[4] = '{1, 3, 5, 5, 8, 8, 0, -1, 10, 3, 1, 1, 2, 0};
    nom = tbl[0];
    zro = tbl[2];
    p9  = '{1, 9, 12, 14, 25, 27, 30, 33, 34, 9, 2, 3, 10, 4};

    bus.run    = 1'b0;
    bus.single = 1'b0;
    bus.abort  = 1'b0;
    set_dur(nom);
    repeat (3) @(negedge clk_2M5);
    q.push_back(idle(0, 0));
    run_ticks(1);
    reset = 1'b0;
    q.push_back(idle(0, 0));
    q.push_back(idle(0, 0));
    run_ticks(2);

    // single-shot table
    for (int i = 0; i < 5; i++) begin
      set_dur(tbl[i]);
      bus.single = 1'b1;
      bus.run    = 1'b1;
      for (int t = 1; t <= tbl[i].d + 2; t++)
        q.push_back(t <= tbl[i].d ? win(tbl[i], t, n) : idle(t, n + 1));
      run_ticks(1);
      bus.run = 1'b0;
      run_ticks(tbl[i].d + 1);
      n++;
    end

    // abort together with run in IDLE
    bus.abort = 1'b1;
    bus.run   = 1'b1;
    q.push_back(idle(1, n));
    q.push_back(idle(2, n));
    run_ticks(1);
    bus.abort = 1'b0;
    bus.run   = 1'b0;
    run_ticks(1);

    // abort during RAMSEY
    set_dur(nom);
    bus.single = 1'b1;
    bus.run    = 1'b1;
    for (int t = 1; t <= 35; t++)
      q.push_back(t <= 15 ? win(nom, t, n) : idle(t, n));
    run_ticks(1);
    bus.run = 1'b0;
    run_ticks(14);
    bus.abort = 1'b1;
    run_ticks(1);
    bus.abort = 1'b0;
    run_ticks(19);

    // reset, then three back-to-back cycles with graceful stop
    reset = 1'b1;
    q.push_back(idle(0, 0));
    run_ticks(1);
    reset = 1'b0;
    n = 0;
    bus.single = 1'b0;
    bus.run    = 1'b1;
    for (int t = 1; t <= 92; t++) begin
      int c;
      c = (t - 1) / 30;
      q.push_back(t <= 90 ? win(nom, t - 30 * c, n + c) : idle(t, n + 3));
    end
    run_ticks(70);
    bus.run = 1'b0;
    run_ticks(22);
    n += 3;

    // pump change during PROBE, run dropped during next MW1
    bus.run = 1'b1;
    for (int t = 1; t <= 66; t++) begin
      if (t <= 30)      q.push_back(win(nom, t, n));
      else if (t <= 64) q.push_back(win(p9, t - 30, n + 1));
      else              q.push_back(idle(t, n + 2));
    end
    run_ticks(27);
    bus.dur_pump = DW'(9);
    run_ticks(16);
    bus.run = 1'b0;
    run_ticks(23);
    n += 2;

    // all-zero durations: END every tick, count saturates
    set_dur(zro);
    bus.run = 1'b1;
    for (int t = 1; t <= 22; t++)
      q.push_back(t <= 20 ? endt(t, n + t) : idle(t, n + 20));
    run_ticks(20);
    bus.run = 1'b0;
    run_ticks(2);
    n += 20;

    // synchronous reset while running
    bus.run = 1'b1;
    for (int t = 1; t <= 5; t++) q.push_back(endt(t, n + t));
    q.push_back(idle(6, 0));
    q.push_back(idle(7, 0));
    run_ticks(5);
    reset   = 1'b1;
    bus.run = 1'b0;
    run_ticks(1);
    reset = 1'b0;
    run_ticks(1);
    n = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
